// File: rtl/alu_pkg.sv
// Shared types and helpers for the sequential ALU adder/subtractor.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Step counter needs at least one bit even when a single step is enough.
    function automatic int cnt_width(input int steps);
        return (steps <= 2) ? 1 : $clog2(steps);
    endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell used to build the ripple slice.
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

// File: rtl/rca_slice.sv
// Combinational SLICE-bit ripple-carry chain; also exposes the carry into its top bit.
module rca_slice #(
    parameter int SLICE = 1
) (
    input  logic [SLICE-1:0] a_i,
    input  logic [SLICE-1:0] b_i,
    input  logic             c_i,
    output logic [SLICE-1:0] s_o,
    output logic             c_o,
    output logic             c_top_o
);

    logic [SLICE:0] carry;

    assign carry[0] = c_i;

    for (genvar i = 0; i < SLICE; i++) begin : g_bit
        full_adder u_fa (
            .a_i (a_i[i]),
            .b_i (b_i[i]),
            .c_i (carry[i]),
            .s_o (s_o[i]),
            .c_o (carry[i+1])
        );
    end

    assign c_o     = carry[SLICE];
    assign c_top_o = carry[SLICE-1];

endmodule

// File: rtl/seq_addsub.sv
// Multi-cycle adder/subtractor: WIDTH-bit operation pushed SLICE bits per clock
// through one shared ripple slice, with valid/ready on both sides.
module seq_addsub
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SLICE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int STEPS = WIDTH / SLICE;
    localparam int CW    = cnt_width(STEPS);
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    if ((WIDTH < 2) || (SLICE < 1) || (WIDTH % SLICE != 0)) begin : g_bad_param
        $error("seq_addsub: WIDTH must be >= 2 and a multiple of SLICE");
    end

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] sum_d;
    logic             carry_q;
    logic             cout_q;
    logic             ovf_q;

    logic [SLICE-1:0] slice_sum;
    logic             slice_cout;
    logic             slice_ctop;

    rca_slice #(
        .SLICE (SLICE)
    ) u_slice (
        .a_i     (a_q[SLICE-1:0]),
        .b_i     (b_q[SLICE-1:0]),
        .c_i     (carry_q),
        .s_o     (slice_sum),
        .c_o     (slice_cout),
        .c_top_o (slice_ctop)
    );

    // Slice results enter at the MSB end so the word is aligned after STEPS shifts.
    if (SLICE == WIDTH) begin : g_sum_full
        assign sum_d = slice_sum;
    end else begin : g_sum_shift
        assign sum_d = {slice_sum, sum_q[WIDTH-1:SLICE]};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        // Subtract as A + ~B + ~borrow.
                        a_q     <= a;
                        b_q     <= (sub == OP_SUB) ? ~b : b;
                        carry_q <= cin ^ sub;
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> SLICE;
                    b_q     <= b_q >> SLICE;
                    sum_q   <= sum_d;
                    carry_q <= slice_cout;
                    cnt_q   <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        cout_q  <= slice_cout;
                        ovf_q   <= slice_ctop ^ slice_cout;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_seq_addsub.sv
// Bench: three builds (SLICE=1/4/8) on shared stimulus, checked against a transaction-level model.
module tb_seq_addsub;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic       out_ready;

    logic       in_ready_w  [3];
    logic       out_valid_w [3];
    logic [7:0] sum_w       [3];
    logic       cout_w      [3];
    logic       ovf_w       [3];

    int n_cmp = 0;
    int n_err = 0;

    int steps_k [3] = '{8, 2, 1};

    always #5 clk = ~clk;

    seq_addsub #(.WIDTH(8), .SLICE(1)) u_s1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[0]),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid_w[0]),
        .out_ready(out_ready), .sum(sum_w[0]), .cout(cout_w[0]), .ovf(ovf_w[0])
    );
    seq_addsub #(.WIDTH(8), .SLICE(4)) u_s4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[1]),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid_w[1]),
        .out_ready(out_ready), .sum(sum_w[1]), .cout(cout_w[1]), .ovf(ovf_w[1])
    );
    seq_addsub #(.WIDTH(8), .SLICE(8)) u_s8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[2]),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid_w[2]),
        .out_ready(out_ready), .sum(sum_w[2]), .cout(cout_w[2]), .ovf(ovf_w[2])
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
        end
    endtask

    // Plain integer arithmetic: A+B+cin or A-B-cin, cout = carry / no-borrow.
    function automatic void ref_op(input logic [7:0] x, input logic [7:0] y, input logic c,
                                   input logic s, output logic [7:0] r, output logic co,
                                   output logic ov);
        int ux, uy, sx, sy, ci, ur, sr;
        ux = int'(x);
        uy = int'(y);
        sx = int'($signed(x));
        sy = int'($signed(y));
        ci = int'(c);
        if (!s) begin
            ur = ux + uy + ci;
            sr = sx + sy + ci;
            co = (ur > 255);
        end else begin
            ur = ux - uy - ci;
            sr = sx - sy - ci;
            co = (ur >= 0);
        end
        r  = ur[7:0];
        ov = (sr > 127) || (sr < -128);
    endfunction

    // Transaction model: 0 = waiting for input, 1 = computing, 2 = holding result.
    int         m_st    [3];
    int         m_rem   [3];
    logic [7:0] m_psum  [3];
    logic       m_pcout [3];
    logic       m_povf  [3];
    logic [7:0] m_sum   [3];
    logic       m_cout  [3];
    logic       m_ovf   [3];
    bit         m_sknown[3];
    bit         m_known = 1'b0;

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                m_st[k]     = 0;
                m_sum[k]    = 8'h00;
                m_cout[k]   = 1'b0;
                m_ovf[k]    = 1'b0;
                m_sknown[k] = 1'b1;
            end else if (m_known) begin
                if (m_st[k] == 0) begin
                    if (in_valid) begin
                        ref_op(a, b, cin, sub, m_psum[k], m_pcout[k], m_povf[k]);
                        m_rem[k]    = steps_k[k];
                        m_st[k]     = 1;
                        m_sknown[k] = 1'b0;
                    end
                end else if (m_st[k] == 1) begin
                    m_rem[k]--;
                    if (m_rem[k] == 0) begin
                        m_st[k]     = 2;
                        m_sum[k]    = m_psum[k];
                        m_cout[k]   = m_pcout[k];
                        m_ovf[k]    = m_povf[k];
                        m_sknown[k] = 1'b1;
                    end
                end else if (out_ready) begin
                    m_st[k] = 0;
                end
            end
        end
        if (!rst_n) m_known = 1'b1;
    end

    always @(posedge clk) begin
        #1;
        if (m_known) begin
            for (int k = 0; k < 3; k++) begin
                check($sformatf("model in_ready[%0d]", k), 8'(in_ready_w[k]), 8'(m_st[k] == 0));
                check($sformatf("model out_valid[%0d]", k), 8'(out_valid_w[k]), 8'(m_st[k] == 2));
                check($sformatf("model cout[%0d]", k), 8'(cout_w[k]), 8'(m_cout[k]));
                check($sformatf("model ovf[%0d]", k), 8'(ovf_w[k]), 8'(m_ovf[k]));
                if (m_sknown[k]) check($sformatf("model sum[%0d]", k), sum_w[k], m_sum[k]);
            end
        end
    end

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 40 && !ok; c++) begin
            @(posedge clk);
            #2;
            ok = in_ready_w[0] && in_ready_w[1] && in_ready_w[2];
        end
        check("drain to idle", 8'(ok), 8'd1);
    endtask

    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tci,
                          input logic tsb, input logic [7:0] e_sum, input logic e_cout,
                          input logic e_ovf, input bit release_out);
        int lat [3];
        bit seen[3];
        for (int k = 0; k < 3; k++) begin
            lat[k]  = 0;
            seen[k] = 1'b0;
        end
        @(negedge clk);
        a = ta; b = tb_v; cin = tci; sub = tsb; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int c = 1; c <= 20 && !(seen[0] && seen[1] && seen[2]); c++) begin
            @(posedge clk);
            #2;
            for (int k = 0; k < 3; k++) begin
                if (!seen[k] && out_valid_w[k]) begin
                    seen[k] = 1'b1;
                    lat[k]  = c;
                end
            end
        end
        for (int k = 0; k < 3; k++) begin
            check($sformatf("latency[%0d] %02h/%02h", k, ta, tb_v), 8'(lat[k]), 8'(steps_k[k]));
            check($sformatf("sum[%0d] %02h/%02h", k, ta, tb_v), sum_w[k], e_sum);
            check($sformatf("cout[%0d] %02h/%02h", k, ta, tb_v), 8'(cout_w[k]), 8'(e_cout));
            check($sformatf("ovf[%0d] %02h/%02h", k, ta, tb_v), 8'(ovf_w[k]), 8'(e_ovf));
        end
        if (release_out) begin
            @(negedge clk) out_ready = 1'b1;
            @(negedge clk) out_ready = 1'b0;
        end
    endtask

    initial begin
        logic [7:0] r;
        logic       co, ov;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = 8'h00; b = 8'h00; cin = 1'b0; sub = 1'b0;

        ref_op(8'h5A, 8'h3C, 1'b0, 1'b0, r, co, ov);
        check("pin add 5A+3C", {r[7:2], co, ov}, {8'h96 >> 2, 1'b0, 1'b1});
        check("pin add 5A+3C low", 8'(r[1:0]), 8'(2'b10));
        ref_op(8'hFF, 8'h01, 1'b0, 1'b0, r, co, ov);
        check("pin add FF+01", {r, co, ov} >> 2, 10'({8'h00, 1'b1, 1'b0}) >> 2);
        ref_op(8'h80, 8'h01, 1'b0, 1'b1, r, co, ov);
        check("pin sub 80-01 sum", r, 8'h7F);
        check("pin sub 80-01 flags", 8'({co, ov}), 8'd3);

        repeat (2) @(posedge clk);
        #2;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("reset in_ready[%0d]", k), 8'(in_ready_w[k]), 8'd1);
            check($sformatf("reset out_valid[%0d]", k), 8'(out_valid_w[k]), 8'd0);
            check($sformatf("reset sum[%0d]", k), sum_w[k], 8'h00);
            check($sformatf("reset flags[%0d]", k), 8'({cout_w[k], ovf_w[k]}), 8'd0);
        end
        @(negedge clk) rst_n = 1'b1;

        run_op(8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1, 1'b1);
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        run_op(8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0, 1'b1);
        run_op(8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0, 1'b1);
        run_op(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b1);
        run_op(8'h00, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1);

        // Backpressure with new operands offered while results are held.
        run_op(8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1; a = 8'($urandom); b = 8'($urandom);
            cin = 1'($urandom); sub = 1'($urandom);
            @(posedge clk);
            #2;
            for (int k = 0; k < 3; k++) begin
                check($sformatf("hold sum[%0d]", k), sum_w[k], 8'h96);
                check($sformatf("hold flags[%0d]", k), 8'({cout_w[k], ovf_w[k]}), 8'd1);
                check($sformatf("hold in_ready[%0d]", k), 8'(in_ready_w[k]), 8'd0);
            end
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        #2;
        for (int k = 0; k < 3; k++)
            check($sformatf("release idle[%0d]", k), 8'(in_ready_w[k]), 8'd1);
        @(negedge clk) out_ready = 1'b0;

        // Reset during RUN step 3 of the SLICE=1 build (others are in DONE).
        @(negedge clk);
        a = 8'hC3; b = 8'h5A; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("midrun rst in_ready[%0d]", k), 8'(in_ready_w[k]), 8'd1);
            check($sformatf("midrun rst out_valid[%0d]", k), 8'(out_valid_w[k]), 8'd0);
            check($sformatf("midrun rst sum[%0d]", k), sum_w[k], 8'h00);
        end
        run_op(8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0, 1'b1);

        // Random traffic with random backpressure and occasional reset.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            rst_n     = ($urandom_range(0, 299) != 0);
            in_valid  = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            a         = 8'($urandom);
            b         = 8'($urandom);
            cin       = 1'($urandom);
            sub       = 1'($urandom);
        end
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        wait_idle();
        repeat (3) @(posedge clk);
        #3;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/seq_addsub.md
Name: seq_addsub

Overview:
- Parametrised multi-cycle adder/subtractor for the 8-bit ALU datapath; next generation of the single-bit full adder.
- Processes a WIDTH-bit operation SLICE bits per clock through one shared ripple slice.
- Uses valid/ready handshakes on both input and output, and reports carry-out and signed overflow.
- Sits between the ALU operand registers and the result mux; trades latency for area.

Parameters:
- WIDTH, 8, operand/result width in bits; must be >= 2.
- SLICE, 1, bits processed per cycle; WIDTH % SLICE == 0 is required (elaboration error otherwise).
- STEPS, WIDTH/SLICE, derived localparam; number of compute cycles.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  operands/mode present.
- in_ready  out  1  block can accept an operation.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in (add) / borrow-in (sub).
- sub  in  1  0 = A+B+cin; 1 = A-B-cin.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result.
- cout  out  1  raw carry out of the MSB (sub: 1 = no borrow).
- ovf  out  1  two's-complement overflow.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state=IDLE, step counter=0, all operand/sum/carry registers=0.
  - Outputs: in_ready=1, out_valid=0, sum=0, cout=0, ovf=0.
  - Reset applies in any state, including mid-RUN or mid-DONE; the in-flight operation is discarded with no partial output.
- All outputs are registered or decoded directly from state. There is no combinational path from in_valid/out_ready to in_ready/out_valid.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid at an edge: capture a; capture b_eff = sub ? ~b : b; carry = cin ^ sub (sub computes A + ~B + ~cin). Clear the counter and go to RUN.
  - Inputs in any other state are ignored.
- RUN:
  - in_ready=0.
  - Each cycle: the low SLICE bits of the A and b_eff shift registers plus carry go through the slice adder. The slice sum shifts into the top of the sum register, the operand registers shift right by SLICE, carry updates, and the counter increments.
  - In the last step (counter == STEPS-1), latch the carry into the MSB: ovf = c_msb_in ^ c_out, cout = c_out. Then go to DONE.
- DONE:
  - out_valid=1; sum/cout/ovf are held stable.
  - On out_ready at an edge: go to IDLE, and out_valid drops on the next cycle.
  - There is no back-to-back accept in DONE; in_ready returns only in IDLE.
- Latency: out_valid rises STEPS cycles after the accepting edge. Throughput is one op per STEPS+2 cycles with out_ready tied high.
- Arithmetic is modulo 2^WIDTH. Carry/overflow semantics are identical for SLICE=1 and SLICE=WIDTH.
- Boundary cases:
  - SLICE == WIDTH gives a single RUN cycle.
  - out_ready held low keeps the block in DONE indefinitely with outputs frozen.
  - out_ready asserted outside DONE has no effect.
- Counter width is clog2(STEPS) with a minimum of 1 bit.

Decomposition:
- Package alu_pkg:
  - State enum typedef (IDLE/RUN/DONE).
  - Opcode constants OP_ADD=0, OP_SUB=1.
  - Helper function for counter width.
- Sub-module rca_slice:
  - Combinational SLICE-bit ripple chain built from full_adder instances.
  - Outputs the SLICE-bit sum, the carry out, and the carry into its top bit (used for ovf).

Test Plan:
- WIDTH=8, SLICE=1, add 0x5A+0x3C cin=0 -> sum=0x96, cout=0, ovf=1; out_valid exactly 8 cycles after the accept edge.
- Add 0xFF+0x01 cin=0 -> sum=0x00, cout=1, ovf=0. Add 0x00+0x00 cin=1 -> sum=0x01, cout=0, ovf=0.
- Sub 0x10-0x20 cin=0 -> sum=0xF0, cout=0, ovf=0. Sub 0x80-0x01 cin=0 -> sum=0x7F, cout=1, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while driving in_valid with new operands -> sum/cout/ovf unchanged, in_ready=0, new operands ignored; IDLE one cycle after out_ready=1.
- Reset: rst_n=0 for one edge at RUN step 3 -> next cycle in_ready=1, out_valid=0, sum=0; a following op 0x01+0x01 gives 0x02.
- SLICE=4 and SLICE=8 builds: 0x5A+0x3C gives the same results as SLICE=1, with out_valid after 2 and 1 cycles respectively.
